ip_sequencer: RTL and testbench

Control FSM that sequences the instruction pointer through fetch, execute and advance phases.
- Drives the pointer's update_enable, adj and reset_enable inputs.
- Handshakes instruction fetch with memory and latches the fetched word.
- Waits for the execute unit, counts retired instructions and detects fetch timeouts.
- Sits between the instruction pointer, instruction memory port and execute unit in the CPU core.

---
 rtl/ip_sequencer.sv | 141 ++++++++++++++
 tb/tb_ip_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ip_sequencer.sv
// Instruction-pointer sequencer: walks the core through FETCH, EXECUTE and ADVANCE,
// driving the pointer's control inputs, latching fetched words and counting retirements.
module ip_sequencer #(
    parameter int WORD_SIZE     = 16,
    parameter int FETCH_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 soft_reset,
    output logic                 fetch_req,
    input  logic                 fetch_ack,
    input  logic [WORD_SIZE-1:0] instr_in,
    output logic [WORD_SIZE-1:0] ir,
    output logic                 ir_valid,
    input  logic                 exec_done,
    input  logic                 branch_taken,
    input  logic signed [WORD_SIZE-1:0] branch_offset,
    input  logic                 halt_req,
    output logic                 ip_update_enable,
    output logic signed [WORD_SIZE-1:0] ip_adj,
    output logic                 ip_reset_enable,
    output logic [WORD_SIZE-1:0] retired,
    output logic                 fault,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_HALTED  = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam int TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);
    localparam logic [WORD_SIZE-1:0] ONE  = WORD_SIZE'(1);

    state_t                    state_q, state_d;
    logic [WORD_SIZE-1:0]      ir_q, ir_d;
    logic                      ir_valid_q, ir_valid_d;
    logic signed [WORD_SIZE-1:0] ip_adj_q, ip_adj_d;
    logic [WORD_SIZE-1:0]      retired_q, retired_d;
    logic                      fault_q, fault_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            ip_adj_q   <= '0;
            retired_q  <= '0;
            fault_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ip_adj_q   <= ip_adj_d;
            retired_q  <= retired_d;
            fault_q    <= fault_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ip_adj_d   = ip_adj_q;
        retired_d  = retired_q;
        fault_d    = fault_q;
        tmo_d      = tmo_q;

        case (state_q)
            ST_CLEAR: state_d = ST_IDLE;
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // An ack on the final allowed cycle is checked first so it beats the timeout.
                if (fetch_ack) begin
                    ir_d       = instr_in;
                    ir_valid_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_EXECUTE;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (exec_done) begin
                    ir_valid_d = 1'b0;
                    retired_d  = retired_q + ONE;
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end else if (branch_taken) begin
                        ip_adj_d = branch_offset;
                        state_d  = ST_ADVANCE;
                    end else begin
                        ip_adj_d = ONE;
                        state_d  = ST_ADVANCE;
                    end
                end
            end
            ST_ADVANCE: state_d = ST_FETCH;
            ST_HALTED: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_CLEAR;
        endcase

        // soft_reset overrides every transition but leaves the retire count alone.
        if (soft_reset) begin
            state_d    = ST_CLEAR;
            ir_valid_d = 1'b0;
            tmo_d      = '0;
            fault_d    = 1'b0;
        end
    end

    assign fetch_req        = (state_q == ST_FETCH);
    assign ip_update_enable = (state_q == ST_ADVANCE);
    assign ip_reset_enable  = (state_q == ST_CLEAR);
    assign ir               = ir_q;
    assign ir_valid         = ir_valid_q;
    assign ip_adj           = ip_adj_q;
    assign retired          = retired_q;
    assign fault            = fault_q;
    assign state            = state_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Directed bench for ip_sequencer: a vector table for the main sequencing flow plus
// hand-written sequences for ack-on-last-cycle and asynchronous reset mid-fetch.
module tb_ip_sequencer;

    localparam logic [2:0] CLR = 3'd0, IDL = 3'd1, FET = 3'd2, EXE = 3'd3,
                           ADV = 3'd4, HLT = 3'd5, FLT = 3'd6;

    typedef struct {
        logic        start;
        logic        srst;
        logic        ack;
        logic [15:0] instr;
        logic        done;
        logic        br;
        logic [15:0] off;
        logic        halt;
        logic [2:0]  e_state;
        logic [15:0] e_ir;
        logic        e_valid;
        logic [15:0] e_adj;
        logic [15:0] e_ret;
        logic        e_fault;
        logic [15:0] e_ip;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, soft_reset = 1'b0;
    logic        fetch_req, fetch_ack = 1'b0;
    logic [15:0] instr_in = '0;
    logic [15:0] ir;
    logic        ir_valid;
    logic        exec_done = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        ip_update_enable, ip_reset_enable;
    logic [15:0] ip_adj, retired;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] ip;

    int compared   = 0;
    int mismatched = 0;
    vec_t tbl[$];

    ip_sequencer #(.WORD_SIZE(16), .FETCH_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .soft_reset(soft_reset),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .instr_in(instr_in),
        .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .halt_req(halt_req),
        .ip_update_enable(ip_update_enable), .ip_adj(ip_adj),
        .ip_reset_enable(ip_reset_enable), .retired(retired), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // Stand-in for the instruction pointer the sequencer drives.
    always @(posedge clk) begin
        if (ip_reset_enable) ip <= '0;
        else if (ip_update_enable) ip <= ip + ip_adj;
    end

    function automatic vec_t mk(logic st, logic sr, logic ak, logic [15:0] ins, logic dn,
                                logic b, logic [15:0] o, logic h, logic [2:0] es,
                                logic [15:0] eir, logic ev, logic [15:0] ea,
                                logic [15:0] er, logic ef, logic [15:0] eip);
        vec_t v;
        v.start = st; v.srst = sr; v.ack = ak; v.instr = ins; v.done = dn;
        v.br = b; v.off = o; v.halt = h; v.e_state = es; v.e_ir = eir;
        v.e_valid = ev; v.e_adj = ea; v.e_ret = er; v.e_fault = ef; v.e_ip = eip;
        return v;
    endfunction

    task automatic checkField(string name, logic [15:0] act, logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(vec_t v, string tag);
        checkField({tag, " state"}, 16'(state), 16'(v.e_state));
        checkField({tag, " fetch_req"}, 16'(fetch_req), 16'(v.e_state == FET));
        checkField({tag, " ip_update_enable"}, 16'(ip_update_enable), 16'(v.e_state == ADV));
        checkField({tag, " ip_reset_enable"}, 16'(ip_reset_enable), 16'(v.e_state == CLR));
        checkField({tag, " ir"}, ir, v.e_ir);
        checkField({tag, " ir_valid"}, 16'(ir_valid), 16'(v.e_valid));
        checkField({tag, " ip_adj"}, ip_adj, v.e_adj);
        checkField({tag, " retired"}, retired, v.e_ret);
        checkField({tag, " fault"}, 16'(fault), 16'(v.e_fault));
        checkField({tag, " ip"}, ip, v.e_ip);
    endtask

    // Inputs are applied just after an edge; expectations describe the state after the next edge.
    task automatic applyStimulus(vec_t v);
        start = v.start; soft_reset = v.srst; fetch_ack = v.ack; instr_in = v.instr;
        exec_done = v.done; branch_taken = v.br; branch_offset = v.off; halt_req = v.halt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Sequencing table: three plain instructions, branches, halt, zero offset, timeout.
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, IDL,16'h0000,0,16'h0000,0,0,16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, IDL,16'h0000,0,16'h0000,0,0,16'd0));
        tbl.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0, FET,16'h0000,0,16'h0000,0,0,16'd0));
        tbl.push_back(mk(0,0,1,16'h1111,0,0,16'h0000,0, EXE,16'h1111,1,16'h0000,0,0,16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,1,0,16'h0000,0, ADV,16'h1111,0,16'h0001,1,0,16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h1111,0,16'h0001,1,0,16'd1));
        tbl.push_back(mk(0,0,1,16'h2222,0,0,16'h0000,0, EXE,16'h2222,1,16'h0001,1,0,16'd1));
        tbl.push_back(mk(0,0,0,16'h0000,1,0,16'h0000,0, ADV,16'h2222,0,16'h0001,2,0,16'd1));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h2222,0,16'h0001,2,0,16'd2));
        tbl.push_back(mk(0,0,1,16'h3333,0,0,16'h0000,0, EXE,16'h3333,1,16'h0001,2,0,16'd2));
        tbl.push_back(mk(0,0,0,16'h0000,1,0,16'h0000,0, ADV,16'h3333,0,16'h0001,3,0,16'd2));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h3333,0,16'h0001,3,0,16'd3));
        tbl.push_back(mk(0,0,1,16'h4444,0,0,16'h0000,0, EXE,16'h4444,1,16'h0001,3,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,1,1,16'h0002,0, ADV,16'h4444,0,16'h0002,4,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h4444,0,16'h0002,4,0,16'd5));
        tbl.push_back(mk(1,0,0,16'h0000,1,1,16'h0007,1, FET,16'h4444,0,16'h0002,4,0,16'd5));
        tbl.push_back(mk(0,0,1,16'h5555,0,0,16'h0000,0, EXE,16'h5555,1,16'h0002,4,0,16'd5));
        tbl.push_back(mk(0,0,0,16'h0000,1,1,16'hFFFE,0, ADV,16'h5555,0,16'hFFFE,5,0,16'd5));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h5555,0,16'hFFFE,5,0,16'd3));
        tbl.push_back(mk(0,0,1,16'h6666,0,0,16'h0000,0, EXE,16'h6666,1,16'hFFFE,5,0,16'd3));
        tbl.push_back(mk(1,0,1,16'h7777,0,0,16'h0000,0, EXE,16'h6666,1,16'hFFFE,5,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,1,1,16'h000A,1, HLT,16'h6666,0,16'hFFFE,6,0,16'd3));
        tbl.push_back(mk(0,0,1,16'h7777,1,0,16'h0000,0, HLT,16'h6666,0,16'hFFFE,6,0,16'd3));
        tbl.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0, FET,16'h6666,0,16'hFFFE,6,0,16'd3));
        tbl.push_back(mk(0,0,1,16'h8888,0,0,16'h0000,0, EXE,16'h8888,1,16'hFFFE,6,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,1,1,16'h0000,0, ADV,16'h8888,0,16'h0000,7,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h8888,0,16'h0000,7,0,16'd3));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FET,16'h8888,0,16'h0000,7,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, FLT,16'h8888,0,16'h0000,7,1,16'd3));
        tbl.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0, FLT,16'h8888,0,16'h0000,7,1,16'd3));
        tbl.push_back(mk(0,0,1,16'h1234,1,0,16'h0000,0, FLT,16'h8888,0,16'h0000,7,1,16'd3));
        tbl.push_back(mk(0,1,0,16'h0000,0,0,16'h0000,0, CLR,16'h8888,0,16'h0000,7,0,16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, IDL,16'h8888,0,16'h0000,7,0,16'd0));
        tbl.push_back(mk(1,1,0,16'h0000,0,0,16'h0000,0, CLR,16'h8888,0,16'h0000,7,0,16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0, IDL,16'h8888,0,16'h0000,7,0,16'd0));

        // Power-on reset: CLEAR with everything zero while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput(mk(0,0,0,0,0,0,0,0, CLR,16'h0000,0,16'h0000,0,0,16'd0), "reset");
        reset = 1'b0;
        checkOutput(mk(0,0,0,0,0,0,0,0, CLR,16'h0000,0,16'h0000,0,0,16'd0), "release");

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("vec%0d", i));
        end

        // Ack arriving on the eighth and last allowed FETCH cycle beats the timeout.
        applyStimulus(mk(1,0,0,0,0,0,0,0, FET,16'h8888,0,16'h0000,7,0,16'd0));
        checkOutput(mk(1,0,0,0,0,0,0,0, FET,16'h8888,0,16'h0000,7,0,16'd0), "late_start");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(mk(0,0,0,0,0,0,0,0, FET,16'h8888,0,16'h0000,7,0,16'd0));
            checkOutput(mk(0,0,0,0,0,0,0,0, FET,16'h8888,0,16'h0000,7,0,16'd0),
                        $sformatf("late_wait%0d", i));
        end
        applyStimulus(mk(0,0,1,16'h9999,0,0,0,0, EXE,16'h9999,1,16'h0000,7,0,16'd0));
        checkOutput(mk(0,0,1,16'h9999,0,0,0,0, EXE,16'h9999,1,16'h0000,7,0,16'd0), "late_ack");
        applyStimulus(mk(0,0,0,0,1,0,0,0, ADV,16'h9999,0,16'h0001,8,0,16'd0));
        checkOutput(mk(0,0,0,0,1,0,0,0, ADV,16'h9999,0,16'h0001,8,0,16'd0), "late_done");
        applyStimulus(mk(0,0,0,0,0,0,0,0, FET,16'h9999,0,16'h0001,8,0,16'd1));
        checkOutput(mk(0,0,0,0,0,0,0,0, FET,16'h9999,0,16'h0001,8,0,16'd1), "late_adv");

        // Asynchronous reset in the middle of a FETCH cycle, followed by a stale ack.
        #3;
        reset = 1'b1;
        #1;
        checkOutput(mk(0,0,0,0,0,0,0,0, CLR,16'h0000,0,16'h0000,0,0,16'd1), "async_rst");
        fetch_ack = 1'b1;
        instr_in  = 16'hABCD;
        @(posedge clk);
        #1;
        checkOutput(mk(0,0,0,0,0,0,0,0, CLR,16'h0000,0,16'h0000,0,0,16'd0), "rst_held");
        reset = 1'b0;
        applyStimulus(mk(0,0,1,16'hABCD,0,0,0,0, IDL,16'h0000,0,16'h0000,0,0,16'd0));
        checkOutput(mk(0,0,1,16'hABCD,0,0,0,0, IDL,16'h0000,0,16'h0000,0,0,16'd0), "stale_ack");
        applyStimulus(mk(0,0,0,0,0,0,0,0, IDL,16'h0000,0,16'h0000,0,0,16'd0));
        checkOutput(mk(0,0,0,0,0,0,0,0, IDL,16'h0000,0,16'h0000,0,0,16'd0), "post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
